free_list_ctrl: RTL and testbench
=================================

Name: free_list_ctrl

Overview:
Sequences the single-ported physical-register free list in the rename stage.
- Merges two release sources (commit retire, squash recovery) through a small 2-write/1-read release queue into the free list's one enqueue port, one register per cycle.
- Runs the rename allocation handshake against the free list's registered dequeue result, stalling rename while the list is empty.
- Keeps a free-register count for rename/dispatch throttling.

Parameters:
NUM_PHYS_REGS, 64, number of physical registers managed by the free list
LOG_PHYS, $clog2(NUM_PHYS_REGS), physical register index width
RELQ_DEPTH, 8, release queue entries; power of two, >= 2
INIT_FREE, 64, free-register count loaded at reset; must be <= NUM_PHYS_REGS

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-low reset
Alloc_Req_IN  in  1  rename requests one physical register
Alloc_Valid_OUT  out  1  allocation completes this cycle; Alloc_Reg_OUT valid
Alloc_Reg_OUT  out  LOG_PHYS  allocated register
Alloc_Stall_OUT  out  1  high while FSM in STARVED
Commit_Valid_IN  in  1  commit releases Commit_Reg_IN
Commit_Reg_IN  in  LOG_PHYS  register freed at commit
Squash_Valid_IN  in  1  recovery releases Squash_Reg_IN
Squash_Reg_IN  in  LOG_PHYS  register freed by squash
Release_Ready_OUT  out  1  release queue has >= 2 free entries
FL_Enqueue_OUT  out  1  enqueue strobe to free list
FL_Data_OUT  out  LOG_PHYS  register to enqueue
FL_Dequeue_OUT  out  1  dequeue strobe to free list
FL_DequeueResult_IN  in  1  free list dequeue success; valid the cycle after FL_Dequeue_OUT
FL_Data_IN  in  LOG_PHYS  dequeued register; valid with FL_DequeueResult_IN
Free_Count_OUT  out  LOG_PHYS+1  controller's free-register count
Overflow_OUT  out  1  sticky error flag

Behaviour:
Reset (RESET low at posedge):
- Release queue emptied; FSM to IDLE; Overflow_OUT=0; Free_Count_OUT=INIT_FREE.
- All other outputs 0 in the following cycle.
- A dequeue in flight at reset has its result ignored. The free list shares RESET and reinitialises, so no register is leaked.

Release queue:
- Push order within a cycle: commit, then squash. Both in one cycle occupy two consecutive entries.
- Release_Ready_OUT = (RELQ_DEPTH - occupancy) >= 2, computed from registered occupancy.
- A valid asserted while Release_Ready_OUT is low is dropped and sets Overflow_OUT.
- No bypass: an entry pushed at edge t is visible at the head from cycle t+1.
- FL_Enqueue_OUT = queue non-empty; FL_Data_OUT = head entry, combinational from state. Pop at every edge where FL_Enqueue_OUT=1.
- Pointers wrap modulo RELQ_DEPTH. Full and empty are distinguished by an occupancy counter of width $clog2(RELQ_DEPTH)+1.
- Simultaneous 2 pushes + 1 pop nets +1 occupancy.

Allocation FSM (states IDLE, PENDING, STARVED):
- IDLE: if Alloc_Req_IN, assert FL_Dequeue_OUT (combinational) and go to PENDING. Otherwise stay.
- PENDING: FL_Dequeue_OUT=0.
  - If FL_DequeueResult_IN=1: Alloc_Valid_OUT=1, Alloc_Reg_OUT=FL_Data_IN (combinational pass-through); go to IDLE.
  - If 0: go to STARVED.
  - Alloc_Req_IN must stay high from IDLE issue until Alloc_Valid_OUT. Best-case throughput is one allocation per 2 cycles.
- STARVED: Alloc_Stall_OUT=1.
  - If Alloc_Req_IN=0: go to IDLE.
  - Else if a free-list enqueue fired in the previous cycle (registered enq_d): assert FL_Dequeue_OUT and go to PENDING.
  - Else stay.
- Alloc_Valid_OUT and Alloc_Reg_OUT are 0 outside a PENDING success.

Free count:
- +1 on an edge with FL_Enqueue_OUT=1; -1 on an edge with PENDING success; both on the same edge = unchanged.
- Increment beyond NUM_PHYS_REGS saturates and sets Overflow_OUT.
- Decrement below 0 saturates at 0 and sets Overflow_OUT.
- Overflow_OUT clears only on reset.

Decomposition:
- Package fl_ctrl_pkg: FSM state enum {IDLE, PENDING, STARVED}, LOG_PHYS derivation helper, count-width constant.
- One sub-module: fl_release_queue. Parameterised 2-write/1-read FIFO with occupancy output, used by free_list_ctrl.
- FSM and free counter stay in the top module.

Test Plan:
1. Reset, INIT_FREE=64; hold Alloc_Req_IN; free list returns result=1, data=5 -> FL_Dequeue_OUT in cycle 1, Alloc_Valid_OUT=1 and Alloc_Reg_OUT=5 in cycle 2, Free_Count_OUT=63 in cycle 3.
2. Commit reg 10 and squash reg 11 in the same cycle -> FL_Enqueue_OUT on the next two cycles with FL_Data_OUT=10 then 11; Free_Count_OUT +2.
3. Fill the queue (RELQ_DEPTH=8) with no drain stubbed -> Release_Ready_OUT=0 at occupancy 7; an extra push is dropped and Overflow_OUT=1.
4. Dequeue result=0 -> STARVED with Alloc_Stall_OUT=1, no FL_Dequeue_OUT. Commit reg 3 -> enqueue in the next cycle, retry dequeue in the cycle after, Alloc_Reg_OUT=3 returned.
5. RESET low while in PENDING -> next cycle: FSM IDLE, all outputs 0, Free_Count_OUT=INIT_FREE, stale FL_DequeueResult_IN ignored.
6. Enqueue and successful dequeue on the same edge -> Free_Count_OUT unchanged; pointer wrap after 9 pushes/pops preserves FIFO order.

Source files
------------

// File: rtl/fl_ctrl_pkg.sv
// Shared types and width helpers for the rename-stage free-list controller.
package fl_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    STARVED = 2'd2
  } fl_state_e;

  function automatic int log_phys_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // The count must reach NUM_PHYS_REGS itself, hence one bit above the index width.
  function automatic int count_w(input int n);
    return log_phys_w(n) + 1;
  endfunction

  localparam int FL_DEFAULT_REGS  = 64;
  localparam int FL_DEFAULT_CNT_W = count_w(FL_DEFAULT_REGS);

endpackage

// File: rtl/fl_release_queue.sv
// Two-write/one-read release FIFO; port 0 is written before port 1 when both push.
module fl_release_queue
  import fl_ctrl_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 6,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int OCC_W = PTR_W + 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push0_i,
  input  logic [W-1:0]     data0_i,
  input  logic             push1_i,
  input  logic [W-1:0]     data1_i,
  input  logic             pop_i,
  output logic [W-1:0]     head_o,
  output logic [OCC_W-1:0] occ_o
);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_slot1;
  logic [OCC_W-1:0] occ_q, occ_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_slot1 = push0_i ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    wr_ptr_d = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_i);
    occ_d    = occ_q + OCC_W'(push0_i) + OCC_W'(push1_i) - OCC_W'(pop_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push0_i) mem_q[wr_ptr_q] <= data0_i;
    if (push1_i) mem_q[wr_slot1] <= data1_i;
  end

  assign head_o = mem_q[rd_ptr_q];
  assign occ_o  = occ_q;

endmodule

// File: rtl/free_list_ctrl.sv
// Rename-stage free-list sequencer: merges releases into the single enqueue port,
// runs the allocation handshake against the registered dequeue result, tracks free count.
module free_list_ctrl
  import fl_ctrl_pkg::*;
#(
  parameter int NUM_PHYS_REGS = 64,
  parameter int LOG_PHYS      = log_phys_w(NUM_PHYS_REGS),
  parameter int RELQ_DEPTH    = 8,
  parameter int INIT_FREE     = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Alloc_Req_IN,
  output logic                Alloc_Valid_OUT,
  output logic [LOG_PHYS-1:0] Alloc_Reg_OUT,
  output logic                Alloc_Stall_OUT,
  input  logic                Commit_Valid_IN,
  input  logic [LOG_PHYS-1:0] Commit_Reg_IN,
  input  logic                Squash_Valid_IN,
  input  logic [LOG_PHYS-1:0] Squash_Reg_IN,
  output logic                Release_Ready_OUT,
  output logic                FL_Enqueue_OUT,
  output logic [LOG_PHYS-1:0] FL_Data_OUT,
  output logic                FL_Dequeue_OUT,
  input  logic                FL_DequeueResult_IN,
  input  logic [LOG_PHYS-1:0] FL_Data_IN,
  output logic [LOG_PHYS:0]   Free_Count_OUT,
  output logic                Overflow_OUT
);

  localparam int CNT_W = LOG_PHYS + 1;
  localparam int OCC_W = $clog2(RELQ_DEPTH) + 1;

  fl_state_e           state_q;
  logic                enq_prev_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                cnt_sat;
  logic [OCC_W-1:0]    relq_occ;
  logic [LOG_PHYS-1:0] relq_head;
  logic                relq_nonempty;
  logic                rel_ready;
  logic                commit_push, squash_push, rel_drop;
  logic                alloc_done;

  // Returns {saturated, next_count}; a clash of +1 and -1 leaves the count alone.
  function automatic logic [CNT_W:0] count_step(input logic [CNT_W-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [CNT_W:0] r;
    r = {1'b0, cnt};
    if (inc && !dec) begin
      if (cnt == CNT_W'(NUM_PHYS_REGS)) r[CNT_W] = 1'b1;
      else                              r[CNT_W-1:0] = cnt + CNT_W'(1);
    end else if (dec && !inc) begin
      if (cnt == '0) r[CNT_W] = 1'b1;
      else           r[CNT_W-1:0] = cnt - CNT_W'(1);
    end
    return r;
  endfunction

  // Release side: accept only when two slots are known free from registered occupancy.
  assign rel_ready     = (relq_occ <= OCC_W'(RELQ_DEPTH - 2));
  assign commit_push   = Commit_Valid_IN & rel_ready;
  assign squash_push   = Squash_Valid_IN & rel_ready;
  assign rel_drop      = (Commit_Valid_IN | Squash_Valid_IN) & ~rel_ready;
  assign relq_nonempty = (relq_occ != '0);

  fl_release_queue #(
    .DEPTH (RELQ_DEPTH),
    .W     (LOG_PHYS)
  ) u_relq (
    .clk_i   (CLK),
    .rst_n_i (RESET),
    .push0_i (commit_push),
    .data0_i (Commit_Reg_IN),
    .push1_i (squash_push),
    .data1_i (Squash_Reg_IN),
    .pop_i   (relq_nonempty),
    .head_o  (relq_head),
    .occ_o   (relq_occ)
  );

  assign FL_Enqueue_OUT    = relq_nonempty;
  assign FL_Data_OUT       = relq_nonempty ? relq_head : '0;
  assign Release_Ready_OUT = rel_ready;

  // Allocation handshake: the free list answers one cycle after the dequeue strobe.
  assign alloc_done      = (state_q == PENDING) & FL_DequeueResult_IN;
  assign Alloc_Valid_OUT = alloc_done;
  assign Alloc_Reg_OUT   = alloc_done ? FL_Data_IN : '0;
  assign Alloc_Stall_OUT = (state_q == STARVED);
  assign FL_Dequeue_OUT  = Alloc_Req_IN &
                           ((state_q == IDLE) | ((state_q == STARVED) & enq_prev_q));

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q    <= IDLE;
      enq_prev_q <= 1'b0;
    end else begin
      enq_prev_q <= relq_nonempty;
      case (state_q)
        IDLE:    if (Alloc_Req_IN) state_q <= PENDING;
        PENDING: state_q <= FL_DequeueResult_IN ? IDLE : STARVED;
        STARVED: begin
          if (!Alloc_Req_IN)   state_q <= IDLE;
          else if (enq_prev_q) state_q <= PENDING;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Free-register count and sticky error flag.
  always_comb begin
    {cnt_sat, cnt_d} = count_step(cnt_q, relq_nonempty, alloc_done);
    ovf_d            = ovf_q | cnt_sat | rel_drop;
  end

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      cnt_q <= CNT_W'(INIT_FREE);
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign Free_Count_OUT = cnt_q;
  assign Overflow_OUT   = ovf_q;

endmodule

// File: tb/tb_free_list_ctrl.sv
// Directed bench for free_list_ctrl with scoreboards for released and allocated registers.
module tb_free_list_ctrl;

  logic       CLK;
  logic       RESET;
  logic       Alloc_Req_IN;
  logic       Alloc_Valid_OUT;
  logic [5:0] Alloc_Reg_OUT;
  logic       Alloc_Stall_OUT;
  logic       Commit_Valid_IN;
  logic [5:0] Commit_Reg_IN;
  logic       Squash_Valid_IN;
  logic [5:0] Squash_Reg_IN;
  logic       Release_Ready_OUT;
  logic       FL_Enqueue_OUT;
  logic [5:0] FL_Data_OUT;
  logic       FL_Dequeue_OUT;
  logic       FL_DequeueResult_IN;
  logic [5:0] FL_Data_IN;
  logic [6:0] Free_Count_OUT;
  logic       Overflow_OUT;

  int errors = 0;
  int checks = 0;
  logic [5:0] exp_fl[$];
  logic [5:0] exp_alloc[$];

  free_list_ctrl #(
    .NUM_PHYS_REGS (64),
    .RELQ_DEPTH    (8),
    .INIT_FREE     (64)
  ) dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .Alloc_Req_IN        (Alloc_Req_IN),
    .Alloc_Valid_OUT     (Alloc_Valid_OUT),
    .Alloc_Reg_OUT       (Alloc_Reg_OUT),
    .Alloc_Stall_OUT     (Alloc_Stall_OUT),
    .Commit_Valid_IN     (Commit_Valid_IN),
    .Commit_Reg_IN       (Commit_Reg_IN),
    .Squash_Valid_IN     (Squash_Valid_IN),
    .Squash_Reg_IN       (Squash_Reg_IN),
    .Release_Ready_OUT   (Release_Ready_OUT),
    .FL_Enqueue_OUT      (FL_Enqueue_OUT),
    .FL_Data_OUT         (FL_Data_OUT),
    .FL_Dequeue_OUT      (FL_Dequeue_OUT),
    .FL_DequeueResult_IN (FL_DequeueResult_IN),
    .FL_Data_IN          (FL_Data_IN),
    .Free_Count_OUT      (Free_Count_OUT),
    .Overflow_OUT        (Overflow_OUT)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Scoreboard pops for any enqueue or allocation the DUT presents this cycle.
  task automatic mon();
    logic [5:0] e;
    if (FL_Enqueue_OUT === 1'b1) begin
      if (exp_fl.size() == 0) chk("fl_enq_unexpected", 32'(FL_Enqueue_OUT), 0);
      else begin
        e = exp_fl.pop_front();
        chk("fl_data", 32'(FL_Data_OUT), 32'(e));
      end
    end
    if (Alloc_Valid_OUT === 1'b1) begin
      if (exp_alloc.size() == 0) chk("alloc_unexpected", 32'(Alloc_Valid_OUT), 0);
      else begin
        e = exp_alloc.pop_front();
        chk("alloc_reg", 32'(Alloc_Reg_OUT), 32'(e));
      end
    end
  endtask

  // Inputs change at negedge; outputs are checked 1-2 time units later, well before posedge.
  task automatic tick();
    #1;
    mon();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_alloc(input logic [5:0] r);
    Alloc_Req_IN = 1'b1;
    #1;
    chk("alloc_issue_deq", 32'(FL_Dequeue_OUT), 1);
    tick();
    FL_DequeueResult_IN = 1'b1;
    FL_Data_IN          = r;
    exp_alloc.push_back(r);
    #1;
    chk("alloc_valid", 32'(Alloc_Valid_OUT), 1);
    tick();
    Alloc_Req_IN        = 1'b0;
    FL_DequeueResult_IN = 1'b0;
    FL_Data_IN          = '0;
  endtask

  initial begin
    RESET               = 1'b0;
    Alloc_Req_IN        = 1'b0;
    Commit_Valid_IN     = 1'b0;
    Commit_Reg_IN       = '0;
    Squash_Valid_IN     = 1'b0;
    Squash_Reg_IN       = '0;
    FL_DequeueResult_IN = 1'b0;
    FL_Data_IN          = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    chk("rst_count", 32'(Free_Count_OUT), 64);
    chk("rst_ovf", 32'(Overflow_OUT), 0);
    chk("rst_valid", 32'(Alloc_Valid_OUT), 0);
    chk("rst_reg", 32'(Alloc_Reg_OUT), 0);
    chk("rst_stall", 32'(Alloc_Stall_OUT), 0);
    chk("rst_enq", 32'(FL_Enqueue_OUT), 0);
    chk("rst_fldata", 32'(FL_Data_OUT), 0);
    chk("rst_deq", 32'(FL_Dequeue_OUT), 0);
    chk("rst_ready", 32'(Release_Ready_OUT), 1);

    // Basic allocation: dequeue in cycle 1, result in cycle 2, count in cycle 3.
    Alloc_Req_IN = 1'b1;
    #1;
    chk("t1_deq", 32'(FL_Dequeue_OUT), 1);
    tick();
    FL_DequeueResult_IN = 1'b1;
    FL_Data_IN          = 6'd5;
    exp_alloc.push_back(6'd5);
    #1;
    chk("t1_deq_pending", 32'(FL_Dequeue_OUT), 0);
    chk("t1_valid", 32'(Alloc_Valid_OUT), 1);
    tick();
    Alloc_Req_IN        = 1'b0;
    FL_DequeueResult_IN = 1'b0;
    FL_Data_IN          = '0;
    #1;
    chk("t1_valid_after", 32'(Alloc_Valid_OUT), 0);
    chk("t1_count", 32'(Free_Count_OUT), 63);

    for (int i = 0; i < 30; i++) do_alloc(6'(i + 12));
    #1;
    chk("bulk_count", 32'(Free_Count_OUT), 33);

    // Commit and squash in one cycle.
    Commit_Valid_IN = 1'b1; Commit_Reg_IN = 6'd10;
    Squash_Valid_IN = 1'b1; Squash_Reg_IN = 6'd11;
    exp_fl.push_back(6'd10);
    exp_fl.push_back(6'd11);
    #1;
    chk("t2_ready", 32'(Release_Ready_OUT), 1);
    chk("t2_no_bypass", 32'(FL_Enqueue_OUT), 0);
    tick();
    Commit_Valid_IN = 1'b0;
    Squash_Valid_IN = 1'b0;
    #1;
    chk("t2_enq1", 32'(FL_Enqueue_OUT), 1);
    tick();
    #1;
    chk("t2_enq2", 32'(FL_Enqueue_OUT), 1);
    tick();
    #1;
    chk("t2_enq_done", 32'(FL_Enqueue_OUT), 0);
    chk("t2_count", 32'(Free_Count_OUT), 35);

    // Fill: two pushes and one pop per cycle until occupancy reaches 7.
    for (int k = 0; k < 6; k++) begin
      Commit_Valid_IN = 1'b1; Commit_Reg_IN = 6'(40 + 2 * k);
      Squash_Valid_IN = 1'b1; Squash_Reg_IN = 6'(41 + 2 * k);
      exp_fl.push_back(6'(40 + 2 * k));
      exp_fl.push_back(6'(41 + 2 * k));
      #1;
      chk("t3_ready_open", 32'(Release_Ready_OUT), 1);
      tick();
    end
    Commit_Reg_IN = 6'd63;
    Squash_Reg_IN = 6'd62;
    #1;
    chk("t3_ready_closed", 32'(Release_Ready_OUT), 0);
    chk("t3_ovf_before", 32'(Overflow_OUT), 0);
    tick();
    Commit_Valid_IN = 1'b0;
    Squash_Valid_IN = 1'b0;
    #1;
    chk("t3_ovf_after", 32'(Overflow_OUT), 1);
    repeat (7) tick();
    #1;
    chk("t3_drained", 32'(FL_Enqueue_OUT), 0);
    chk("t3_count", 32'(Free_Count_OUT), 47);

    // Starvation and retry after a commit lands in the free list.
    Alloc_Req_IN = 1'b1;
    tick();
    FL_DequeueResult_IN = 1'b0;
    #1;
    chk("t4_fail_valid", 32'(Alloc_Valid_OUT), 0);
    tick();
    Commit_Valid_IN = 1'b1; Commit_Reg_IN = 6'd3;
    exp_fl.push_back(6'd3);
    #1;
    chk("t4_stall", 32'(Alloc_Stall_OUT), 1);
    chk("t4_no_deq", 32'(FL_Dequeue_OUT), 0);
    tick();
    Commit_Valid_IN = 1'b0;
    #1;
    chk("t4_enq", 32'(FL_Enqueue_OUT), 1);
    chk("t4_no_deq_yet", 32'(FL_Dequeue_OUT), 0);
    tick();
    #1;
    chk("t4_retry_deq", 32'(FL_Dequeue_OUT), 1);
    chk("t4_stall_retry", 32'(Alloc_Stall_OUT), 1);
    tick();
    FL_DequeueResult_IN = 1'b1;
    FL_Data_IN          = 6'd3;
    exp_alloc.push_back(6'd3);
    #1;
    chk("t4_valid", 32'(Alloc_Valid_OUT), 1);
    chk("t4_unstall", 32'(Alloc_Stall_OUT), 0);
    tick();
    Alloc_Req_IN        = 1'b0;
    FL_DequeueResult_IN = 1'b0;
    FL_Data_IN          = '0;
    #1;
    chk("t4_count", 32'(Free_Count_OUT), 47);

    // Enqueue and allocation on the same edge.
    Alloc_Req_IN = 1'b1;
    Commit_Valid_IN = 1'b1; Commit_Reg_IN = 6'd20;
    exp_fl.push_back(6'd20);
    tick();
    Commit_Valid_IN     = 1'b0;
    FL_DequeueResult_IN = 1'b1;
    FL_Data_IN          = 6'd7;
    exp_alloc.push_back(6'd7);
    #1;
    chk("t6_enq", 32'(FL_Enqueue_OUT), 1);
    chk("t6_valid", 32'(Alloc_Valid_OUT), 1);
    tick();
    Alloc_Req_IN        = 1'b0;
    FL_DequeueResult_IN = 1'b0;
    FL_Data_IN          = '0;
    #1;
    chk("t6_count_same", 32'(Free_Count_OUT), 47);

    // Single pushes alternating sources, enough to wrap the pointers.
    for (int i = 0; i < 9; i++) begin
      if (i % 2 == 0) begin
        Commit_Valid_IN = 1'b1; Commit_Reg_IN = 6'(30 + i); Squash_Valid_IN = 1'b0;
      end else begin
        Squash_Valid_IN = 1'b1; Squash_Reg_IN = 6'(30 + i); Commit_Valid_IN = 1'b0;
      end
      exp_fl.push_back(6'(30 + i));
      tick();
    end
    Commit_Valid_IN = 1'b0;
    Squash_Valid_IN = 1'b0;
    tick();
    #1;
    chk("t6_wrap_empty", 32'(FL_Enqueue_OUT), 0);
    chk("t6_wrap_count", 32'(Free_Count_OUT), 56);

    // Reset while an allocation is pending; the stale result must be ignored.
    Alloc_Req_IN = 1'b1;
    tick();
    RESET        = 1'b0;
    Alloc_Req_IN = 1'b0;
    tick();
    RESET               = 1'b1;
    FL_DequeueResult_IN = 1'b1;
    FL_Data_IN          = 6'd9;
    #1;
    chk("t5_valid", 32'(Alloc_Valid_OUT), 0);
    chk("t5_reg", 32'(Alloc_Reg_OUT), 0);
    chk("t5_stall", 32'(Alloc_Stall_OUT), 0);
    chk("t5_deq", 32'(FL_Dequeue_OUT), 0);
    chk("t5_enq", 32'(FL_Enqueue_OUT), 0);
    chk("t5_ovf", 32'(Overflow_OUT), 0);
    chk("t5_count", 32'(Free_Count_OUT), 64);
    tick();
    FL_DequeueResult_IN = 1'b0;
    FL_Data_IN          = '0;

    // Release into a full count saturates at 64 and flags an error.
    Commit_Valid_IN = 1'b1; Commit_Reg_IN = 6'd50;
    exp_fl.push_back(6'd50);
    tick();
    Commit_Valid_IN = 1'b0;
    tick();
    #1;
    chk("sat_hi_count", 32'(Free_Count_OUT), 64);
    chk("sat_hi_ovf", 32'(Overflow_OUT), 1);

    // Drain the count to zero, then one more allocation underflows.
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    #1;
    chk("rst2_ovf", 32'(Overflow_OUT), 0);
    for (int i = 0; i < 64; i++) do_alloc(6'(i));
    #1;
    chk("sat_lo_zero", 32'(Free_Count_OUT), 0);
    chk("sat_lo_ovf_before", 32'(Overflow_OUT), 0);
    do_alloc(6'd1);
    #1;
    chk("sat_lo_count", 32'(Free_Count_OUT), 0);
    chk("sat_lo_ovf", 32'(Overflow_OUT), 1);

    chk("sb_fl_left", 32'(exp_fl.size()), 0);
    chk("sb_alloc_left", 32'(exp_alloc.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
